// File: rtl/bram_verifier.sv
// Strided BRAM read-back checker: issues one read per cycle, compares against an arithmetic sequence.
// Optional BRAM_VERIFY_STOP_ON_ERR_EN: abort the sweep on the first mismatch.
module bram_verifier #(
  parameter int DATA_SZ   = 16,
  parameter int ADDR_SZ   = 8,
  parameter int ADDR_STEP = 3,
  parameter int DATA_STEP = 13
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [ADDR_SZ-1:0] i_base_addr,
  input  logic [DATA_SZ-1:0] i_base_data,
  input  logic [ADDR_SZ:0]   i_count,
  output logic [ADDR_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_rdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [ADDR_SZ-1:0] o_err_addr,
  output logic [ADDR_SZ:0]   o_err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_SZ-1:0] ADDR_INC = ADDR_SZ'(ADDR_STEP);
  localparam logic [DATA_SZ-1:0] DATA_INC = DATA_SZ'(DATA_STEP);
  localparam logic [ADDR_SZ:0]   CNT_ONE  = (ADDR_SZ+1)'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATA_SZ-1:0]   r_cur_data;
  logic [ADDR_SZ:0]     r_remain;
  logic                 r_pipe_vld;
  logic [ADDR_SZ-1:0]   r_pipe_addr;
  logic [DATA_SZ-1:0]   r_pipe_exp;
  logic                 r_err_seen;
  logic                 w_start_ok;
  logic                 w_cmp_miss;
  logic                 w_abort;

  assign w_start_ok = (r_state == S_IDLE) && i_start;
  assign w_cmp_miss = r_pipe_vld && (i_rdata != r_pipe_exp);

`ifdef BRAM_VERIFY_STOP_ON_ERR_EN
  assign w_abort = w_cmp_miss;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_count != '0) ? S_ISSUE : S_DONE;
      S_ISSUE: begin
        if (w_abort)                  w_state_nxt = S_DONE;
        else if (r_remain == CNT_ONE) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cur_data  <= '0;
      r_remain    <= '0;
      r_pipe_vld  <= 1'b0;
      r_pipe_addr <= '0;
      r_pipe_exp  <= '0;
      r_err_seen  <= 1'b0;
      o_raddr     <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_addr  <= '0;
      o_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      o_done  <= (r_state == S_DONE);

      if (w_start_ok) begin
        r_cur_data <= i_base_data;
        r_remain   <= i_count;
        r_err_seen <= 1'b0;
        o_pass     <= 1'b0;
        o_err_addr <= '0;
        o_err_cnt  <= '0;
        o_busy     <= (i_count != '0);
        if (i_count != '0) o_raddr <= i_base_addr;
      end

      // o_raddr always shows the address being issued; it stops on the last one.
      if (r_state == S_ISSUE && !w_abort) begin
        r_pipe_vld  <= 1'b1;
        r_pipe_addr <= o_raddr;
        r_pipe_exp  <= r_cur_data;
        r_cur_data  <= r_cur_data + DATA_INC;
        r_remain    <= r_remain - CNT_ONE;
        if (r_remain != CNT_ONE) o_raddr <= o_raddr + ADDR_INC;
      end else begin
        r_pipe_vld  <= 1'b0;
      end

      if (w_cmp_miss) begin
        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + CNT_ONE;
        if (!r_err_seen) begin
          r_err_seen <= 1'b1;
          o_err_addr <= r_pipe_addr;
        end
      end

      if (r_state == S_DONE) begin
        o_busy <= 1'b0;
        o_pass <= (o_err_cnt == '0);
      end
    end
  end

endmodule

// File: tb/tb_bram_verifier.sv
// Directed bench for bram_verifier with a synchronous-read BRAM model.
module tb_bram_verifier;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CW = AW + 1;

`ifdef BRAM_VERIFY_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [DW-1:0] base_data;
  logic [CW-1:0] count;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic          busy, done, pass;
  logic [AW-1:0] err_addr;
  logic [CW-1:0] err_cnt;
  logic [DW-1:0] mem [256];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rdata <= mem[raddr];

  bram_verifier #(.DATA_SZ(DW), .ADDR_SZ(AW), .ADDR_STEP(3), .DATA_STEP(13)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base_addr),
    .i_base_data(base_data), .i_count(count), .o_raddr(raddr), .i_rdata(rdata),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_addr(err_addr), .o_err_cnt(err_cnt)
  );

  typedef struct {
    int base_addr; int base_data; int count; int f0; int f1;
    int exp_pass; int exp_err_addr; int exp_cnt; int exp_lat; int stop_cnt; int stop_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic int m_addr(input int ba, input int k);
    return (ba + 3 * k) % 256;
  endfunction

  function automatic int m_data(input int bd, input int k);
    return (bd + 13 * k) % 65536;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int ba, input int bd, input int n, input int f0, input int f1);
    for (int i = 0; i < 256; i++) mem[i] = 16'((i * 257) ^ 16'h5A5A);
    for (int k = 0; k < n; k++) mem[m_addr(ba, k)] = 16'(m_data(bd, k));
    if (f0 >= 0) mem[m_addr(ba, f0)] = ~16'(m_data(bd, f0));
    if (f1 >= 0) mem[m_addr(ba, f1)] = ~16'(m_data(bd, f1));
  endtask

  task automatic run_vec(input string nm, input vec_t v, input bit pulse_busy);
    int  cyc, lat, exp_lat, exp_cnt;
    bit  raddr_ok, busy_ok;
    exp_lat = STOP ? v.stop_lat : v.exp_lat;
    exp_cnt = STOP ? v.stop_cnt : v.exp_cnt;
    preload(v.base_addr, v.base_data, v.count, v.f0, v.f1);
    @(negedge clk);
    start     = 1'b1;
    base_addr = AW'(v.base_addr);
    base_data = DW'(v.base_data);
    count     = CW'(v.count);
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 0;
    lat      = -1;
    raddr_ok = 1'b1;
    busy_ok  = 1'b1;
    while (lat < 0 && cyc < 400) begin
      if (done) lat = cyc;
      else begin
        if (busy !== (v.count != 0)) busy_ok = 1'b0;
        if (cyc < v.count && cyc < exp_lat - 1 && raddr !== AW'(m_addr(v.base_addr, cyc)))
          raddr_ok = 1'b0;
        if (pulse_busy) begin
          start     = (cyc == 1);
          base_addr = 8'd100;
          base_data = 16'h0000;
          count     = 9'd2;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk({nm, "_done_lat"}, lat, exp_lat);
    chk({nm, "_busy"}, busy_ok, 1);
    chk({nm, "_raddr_seq"}, raddr_ok, 1);
    chk({nm, "_pass"}, pass, v.exp_pass);
    chk({nm, "_err_addr"}, err_addr, v.exp_err_addr);
    chk({nm, "_err_cnt"}, err_cnt, exp_cnt);
    @(posedge clk); #1;
    chk({nm, "_done_width"}, done, 0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    logic [AW-1:0] got [3];
    int            cyc;
    bit            seen;

    vecs[0] = '{7,   5,       4,   -1, -1, 1, 0,  0, 6,   0, 6};
    vecs[1] = '{7,   5,       4,    2, -1, 0, 13, 1, 6,   1, 5};
    vecs[2] = '{254, 'hFFFA,  3,   -1, -1, 1, 0,  0, 5,   0, 5};
    vecs[3] = '{20,  100,     6,    1,  4, 0, 23, 2, 8,   1, 4};
    vecs[4] = '{0,   0,       5,    4, -1, 0, 12, 1, 7,   1, 7};
    vecs[5] = '{30,  0,       0,   -1, -1, 1, 0,  0, 1,   0, 1};
    vecs[6] = '{9,   'h1234,  1,   -1, -1, 1, 0,  0, 3,   0, 3};
    vecs[7] = '{50,  'hBEEF,  256,  0, 255, 0, 50, 2, 258, 1, 3};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; base_data = '0; count = '0;
    preload(0, 0, 0, -1, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, pass, err_addr, err_cnt, raddr}, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

    // wrap with literal expected words
    preload(0, 0, 0, -1, -1);
    mem[254] = 16'hFFFA; mem[1] = 16'h0007; mem[4] = 16'h0014;
    @(negedge clk);
    start = 1'b1; base_addr = 8'd254; base_data = 16'hFFFA; count = 9'd3;
    @(posedge clk); #1; start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      got[j] = raddr;
      @(posedge clk); #1;
    end
    chk("wrap_raddr0", got[0], 254);
    chk("wrap_raddr1", got[1], 1);
    chk("wrap_raddr2", got[2], 4);
    cyc = 0;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("wrap_done_seen", done, 1);
    chk("wrap_pass", pass, 1);
    chk("wrap_err_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);

    // reset in the middle of a 10-word run
    preload(7, 5, 10, STOP ? -1 : 0, -1);
    @(negedge clk);
    start = 1'b1; base_addr = 8'd7; base_data = 16'd5; count = 9'd10;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrun_busy", busy, 1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrun_reset_outputs", {busy, done, pass, err_addr, err_cnt, raddr}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrun_no_done", seen, 0);
    run_vec("after_reset", vecs[0], 1'b0);

    run_vec("start_while_busy", vecs[0], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram_verifier.md
Name: bram_verifier

Overview:
- Read-side companion to the BRAM pattern writer.
- Sweeps a BRAM read port over a strided address sequence. Compares each word read against an arithmetic expected-data sequence.
- Reports pass/fail, the first failing address and the mismatch count.
- Sits between a bench/control FSM and the read port (i_rclk/i_raddr/o_rdata) of a bram instance; drives the LED status on the Fomu physical bench.

Parameters:
- DATA_SZ, 16, width of compared data word in bits.
- ADDR_SZ, 8, width of BRAM read address in bits.
- ADDR_STEP, 3, address increment per word, modulo 2^ADDR_SZ.
- DATA_STEP, 13, expected-data increment per word, modulo 2^DATA_SZ.

Ports:
- i_clk  input  1  system clock; all logic on posedge.
- i_rst_n  input  1  synchronous active-low reset.
- i_start  input  1  start strobe; sampled only in IDLE.
- i_base_addr  input  ADDR_SZ  first address; latched on accepted start.
- i_base_data  input  DATA_SZ  first expected word; latched on accepted start.
- i_count  input  ADDR_SZ+1  number of words to check; latched on accepted start.
- o_raddr  output  ADDR_SZ  BRAM read address.
- i_rdata  input  DATA_SZ  BRAM read data; valid exactly 1 cycle after o_raddr is presented.
- o_busy  output  1  high from accepted start until the cycle before o_done.
- o_done  output  1  one-cycle strobe at end of run.
- o_pass  output  1  1 if last completed run had zero mismatches; held until next start.
- o_err_addr  output  ADDR_SZ  address of first mismatch of last run; 0 if none.
- o_err_cnt  output  ADDR_SZ+1  mismatches in last run; saturates at all-ones.

Behaviour:
- Reset (i_rst_n=0 at posedge) values: state IDLE; o_raddr=0; o_busy=0; o_done=0; o_pass=0; o_err_addr=0; o_err_cnt=0; compare-valid pipe bit=0.
- Reset mid-run aborts immediately; no o_done is produced.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - i_start=1 latches base address, base data and count.
  - Clears o_pass, o_err_addr, o_err_cnt and the first-error flag.
  - Goes to ISSUE if i_count!=0, otherwise DONE.
  - i_start is ignored in every other state.
- ISSUE:
  - Each cycle: drive o_raddr=cur_addr; set pipe valid=1; record pipe addr/expected = cur_addr/cur_data.
  - Then cur_addr += ADDR_STEP (wraps mod 2^ADDR_SZ) and cur_data += DATA_STEP (wraps mod 2^DATA_SZ); remaining -= 1.
  - When remaining reaches 0, go to DRAIN.
  - Throughput: one address per cycle.
- Compare stage:
  - Runs in any cycle where pipe valid=1; compares i_rdata against pipe expected.
  - On mismatch, o_err_cnt += 1 (saturating).
  - On the first mismatch only, o_err_addr = pipe addr.
- DRAIN: one cycle in which the final compare completes; pipe valid is cleared; go to DONE.
- DONE:
  - o_done=1 for exactly one cycle.
  - o_pass = (err_cnt==0), including the final compare's result.
  - Return to IDLE.
- o_busy is high in ISSUE and DRAIN.
- Latency: start accepted at cycle T → first o_raddr at T+1 → o_done at T+1+N+1 for N words.
- i_count=0: o_done at T+1; o_pass=1.
- i_count=2^ADDR_SZ, or any stride revisit: addresses wrap and repeat; every issued read is checked, no deduplication.
- o_raddr holds its last value when not in ISSUE.
- Only DATA_SZ bits are compared; the block has no knowledge of the BRAM's internal width.

Optional Feature:
- Macro: BRAM_VERIFY_STOP_ON_ERR_EN.
- Defined:
  - The first mismatch detected in the compare stage forces an immediate transition to DONE.
  - Any read still in flight is discarded: pipe valid cleared, remaining words not issued.
  - o_err_cnt is then always 0 or 1.
  - o_done follows the mismatched compare by 1 cycle.
- Undefined: a full sweep always runs; all mismatches are counted.

Test Plan:
- Clean run: preload BRAM with addr 7,10,13,16 = 5,18,31,44; start base_addr=7, base_data=5, count=4. Required: o_raddr 7,10,13,16 on consecutive cycles; o_done 6 cycles after start; o_pass=1; o_err_cnt=0.
- Single fault: same preload but addr 13 = 0x0000. Required: o_pass=0; o_err_addr=13; o_err_cnt=1. With BRAM_VERIFY_STOP_ON_ERR_EN, o_done comes 1 cycle after the 13 compare, and addr 16's data is never compared.
- Wrap: ADDR_SZ=8, base_addr=254, count=3. Required: o_raddr 254, 1, 4. With base_data=0xFFFA, expected data is 0xFFFA, 0x0007, 0x0014.
- Zero count: start with count=0. Required: o_busy never high; o_done the cycle after start; o_pass=1.
- Reset mid-run: assert i_rst_n=0 during ISSUE of a 10-word run. Required: next cycle o_busy=0, o_done=0, all outputs 0. A fresh start afterwards behaves as the clean run.
- Start while busy: pulse i_start during ISSUE with different base values. Required: pulse ignored; the run completes with the original parameters.
